ts_os_counter: RTL
==================

TS_OS_COUNTER -- requirements
Module: ts_os_counter

Interface
REQ-001 SHALL have parameter TARGET_COUNT, default 8: consecutive identical TS count that sets a reached flag, legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port gen, input, 3: current rate; 1 = Gen1, 2 = Gen2, 3..5 = Gen3+.
REQ-005 SHALL have port numberOfDetectedLanes, input, 5: active lane count; legal values 1, 2, 4, 8, 16.
REQ-006 SHALL have port valid, input, 1: one-cycle strobe marking osIn as a complete ordered set per active lane.
REQ-007 SHALL have port osIn, input, 2048: lane L at bits [128L +: 128], symbol k of that lane at [128L+8k +: 8].
REQ-008 SHALL have port clearCounters, input, 1: LTSSM substate-change clear.
REQ-009 SHALL have port ts1Reached, output, 1: every active lane holds TS1 with count >= TARGET_COUNT.
REQ-010 SHALL have port ts2Reached, output, 1: every active lane holds TS2 with count >= TARGET_COUNT.
REQ-011 SHALL have port osValidOut, output, 1: one-cycle pulse per accepted valid.
REQ-012 SHALL have port lane0Type, output, 2: last type on lane 0; 0 = OTHER, 1 = TS1, 2 = TS2.
REQ-013 SHALL have ports rxLinkNum, rxRate and rxTrainingCtrl, output, 8 each: lane 0 symbols 1, 4 and 5 of the last accepted OS.
REQ-014 SHALL have port rxLaneNums, output, 128: symbol 2 of lane L at [8L +: 8].

Function
REQ-015 SHALL classify each active lane as follows when gen is 1 or 2:
- TS1 when symbol 0 = 8'hBC and symbols 6..15 all = 8'h4A.
- TS2 when symbol 0 = 8'hBC and symbols 6..15 all = 8'h45.
- OTHER otherwise.
REQ-016 SHALL classify each active lane as follows when gen is 3..5:
- TS1 when symbol 0 = 8'h1E.
- TS2 when symbol 0 = 8'h2D.
- OTHER otherwise.
REQ-017 SHALL classify every lane as OTHER when gen is 0, 6 or 7.
REQ-018 SHALL keep per-lane state: lastType (2 bit), lastSym (symbols 1..5, 40 bit), count (4 bit).
REQ-019 SHALL apply these per-lane updates on a clock edge with valid=1 and clearCounters=0:
- OTHER: count=0 and lastType=OTHER.
- Type equals lastType and symbols 1..5 equal lastSym: count = count+1, saturating at 15.
- Otherwise: count=1 and lastType/lastSym loaded from the new OS.
REQ-020 SHALL treat lanes with index >= numberOfDetectedLanes as inactive: state forced to zero/OTHER, excluded from the reached flags.
REQ-021 SHALL treat an illegal numberOfDetectedLanes (0, 3, 5..7, 9..15, 17..31) as 1 lane.
REQ-022 SHALL give clearCounters priority over valid in the same cycle: all counts to 0 and all lastType to OTHER, with no osValidOut pulse.
REQ-023 SHALL compute ts1Reached, ts2Reached, lane0Type and the rx* outputs from next-state values and register them, so they are visible immediately after the edge that samples valid (latency 1 edge).
REQ-024 SHALL update rxLinkNum, rxLaneNums, rxRate and rxTrainingCtrl only on an accepted valid where lane 0 classifies TS1 or TS2; otherwise they hold.
REQ-025 SHALL hold all state and outputs when valid=0 and clearCounters=0, and assert osValidOut for exactly one cycle after each accepted valid.
REQ-026 SHALL take gen and numberOfDetectedLanes changes effect from the next valid; stored counts SHALL NOT be reinterpreted.
REQ-027 SHALL keep ts1Reached and ts2Reached mutually exclusive by construction.

Reset
REQ-028 SHALL, while reset=0, asynchronously drive:
- all counts 0, all lastType OTHER, all lastSym 0.
- ts1Reached=0, ts2Reached=0, osValidOut=0, lane0Type=0.
- rxLinkNum, rxRate, rxTrainingCtrl and rxLaneNums all 0.
REQ-029 SHALL, when reset is asserted mid-sequence, discard partial counts; counting restarts from 1 on the first TS after release.

Verification
REQ-030 Gen1, 2 lanes, 8 identical TS1 valid strobes (link 8'h00, lanes 0/1, symbols 6..15 = 4A) -> ts1Reached=0 after the 7th strobe, =1 after the 8th; rxLaneNums[15:0]=16'h0100.
REQ-031 Gen1, 4 lanes, 5 TS1 then a TS1 with lane 2 link number changed, then 7 more identical -> lane 2 count restarts at 1; ts1Reached asserts only after lane 2 reaches 8.
REQ-032 Gen3, 1 lane, 8 strobes with symbol 0 = 2D -> ts2Reached=1, lane0Type=2; a following strobe with symbol 0 = AA -> ts2Reached=0, lane0Type=0.
REQ-033 valid and clearCounters high in the same cycle after 6 TS1 -> counts 0, no osValidOut; 8 further TS1 are required to set ts1Reached.
REQ-034 Gen2, 16 TS2 strobes with TARGET_COUNT=8 -> count saturates at 15, ts2Reached stays 1; reset asserted -> all outputs 0 asynchronously.
REQ-035 numberOfDetectedLanes=3 with lane 0 TS1 x8 and lanes 1..2 garbage -> ts1Reached=1 (single-lane fallback).

Source files
------------

// File: rtl/ts_os_counter.sv
// Per-lane training-sequence ordered-set classifier and consecutive-identical counter.
// Registers TS1/TS2 "reached" flags and lane-0 received fields one edge after each accepted OS.
module ts_os_counter #(
    parameter int unsigned TARGET_COUNT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    gen,
    input  logic [4:0]    numberOfDetectedLanes,
    input  logic          valid,
    input  logic [2047:0] osIn,
    input  logic          clearCounters,
    output logic          ts1Reached,
    output logic          ts2Reached,
    output logic          osValidOut,
    output logic [1:0]    lane0Type,
    output logic [7:0]    rxLinkNum,
    output logic [7:0]    rxRate,
    output logic [7:0]    rxTrainingCtrl,
    output logic [127:0]  rxLaneNums
);

    localparam int unsigned LANES = 16;

    typedef enum logic [1:0] {
        OS_OTHER = 2'd0,
        OS_TS1   = 2'd1,
        OS_TS2   = 2'd2
    } os_type_t;

    os_type_t    type_q [LANES];
    os_type_t    type_d [LANES];
    os_type_t    cls    [LANES];
    logic [39:0] sym_q  [LANES];
    logic [39:0] sym_d  [LANES];
    logic [3:0]  cnt_q  [LANES];
    logic [3:0]  cnt_d  [LANES];

    logic [4:0]  lanes_eff;
    logic        accept;
    logic        ts1_d;
    logic        ts2_d;

    function automatic os_type_t classify(input logic [127:0] lane, input logic [2:0] g);
        logic all_4a;
        logic all_45;
        os_type_t t;
        all_4a = 1'b1;
        all_45 = 1'b1;
        t      = OS_OTHER;
        for (int unsigned k = 6; k < 16; k++) begin
            all_4a &= (lane[8*k +: 8] == 8'h4A);
            all_45 &= (lane[8*k +: 8] == 8'h45);
        end
        case (g)
            3'd1, 3'd2: begin
                if (lane[7:0] == 8'hBC && all_4a)      t = OS_TS1;
                else if (lane[7:0] == 8'hBC && all_45) t = OS_TS2;
            end
            3'd3, 3'd4, 3'd5: begin
                if (lane[7:0] == 8'h1E)      t = OS_TS1;
                else if (lane[7:0] == 8'h2D) t = OS_TS2;
            end
            default: t = OS_OTHER;
        endcase
        return t;
    endfunction

    always_comb begin
        case (numberOfDetectedLanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: lanes_eff = numberOfDetectedLanes;
            default:                       lanes_eff = 5'd1;
        endcase
    end

    assign accept = valid && !clearCounters;

    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            type_d[l] = type_q[l];
            sym_d[l]  = sym_q[l];
            cnt_d[l]  = cnt_q[l];
            cls[l]    = classify(osIn[128*l +: 128], gen);
            if (clearCounters) begin
                type_d[l] = OS_OTHER;
                cnt_d[l]  = '0;
            end else if (valid) begin
                if (l >= 32'(lanes_eff)) begin
                    type_d[l] = OS_OTHER;
                    sym_d[l]  = '0;
                    cnt_d[l]  = '0;
                end else if (cls[l] == OS_OTHER) begin
                    type_d[l] = OS_OTHER;
                    cnt_d[l]  = '0;
                end else if (cls[l] == type_q[l] && osIn[128*l+8 +: 40] == sym_q[l]) begin
                    cnt_d[l] = (cnt_q[l] == 4'd15) ? 4'd15 : cnt_q[l] + 4'd1;
                end else begin
                    type_d[l] = cls[l];
                    sym_d[l]  = osIn[128*l+8 +: 40];
                    cnt_d[l]  = 4'd1;
                end
            end
        end
    end

    // Flags come from next-state so they are visible right after the sampling edge.
    always_comb begin
        ts1_d = 1'b1;
        ts2_d = 1'b1;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (l < 32'(lanes_eff)) begin
                ts1_d &= (type_d[l] == OS_TS1) && (cnt_d[l] >= 4'(TARGET_COUNT));
                ts2_d &= (type_d[l] == OS_TS2) && (cnt_d[l] >= 4'(TARGET_COUNT));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                type_q[l] <= OS_OTHER;
                sym_q[l]  <= '0;
                cnt_q[l]  <= '0;
            end
            ts1Reached     <= 1'b0;
            ts2Reached     <= 1'b0;
            osValidOut     <= 1'b0;
            lane0Type      <= '0;
            rxLinkNum      <= '0;
            rxRate         <= '0;
            rxTrainingCtrl <= '0;
            rxLaneNums     <= '0;
        end else begin
            for (int unsigned l = 0; l < LANES; l++) begin
                type_q[l] <= type_d[l];
                sym_q[l]  <= sym_d[l];
                cnt_q[l]  <= cnt_d[l];
            end
            osValidOut <= accept;
            if (clearCounters || valid) begin
                ts1Reached <= ts1_d;
                ts2Reached <= ts2_d;
                lane0Type  <= type_d[0];
            end
            if (accept && cls[0] != OS_OTHER) begin
                rxLinkNum      <= osIn[15:8];
                rxRate         <= osIn[39:32];
                rxTrainingCtrl <= osIn[47:40];
                for (int unsigned l = 0; l < LANES; l++)
                    rxLaneNums[8*l +: 8] <= osIn[128*l+16 +: 8];
            end
        end
    end

endmodule
